// File: rtl/div16u_seq.sv
// div16u_seq: sequential unsigned restoring divider, one quotient bit per clock.
// Divides a 2W-bit product O by a W-bit operand B, returning quotient A and
// remainder R, with divide-by-zero (dz) and quotient-overflow (ovf) flags.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input handshake carrying O (2W bits) and B (W bits)
//   out_valid/out_ready output handshake carrying A, R, dz, ovf (all registered)
module div16u_seq #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   O,
  input  logic [W-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     A,
  output logic [W-1:0]     R,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_b;

  logic [W:0]      w_t;
  logic            w_ge;
  logic [W-1:0]    w_rem_sub;
  logic [W-1:0]    w_rem_next;
  logic [W-1:0]    w_q_next;
  logic            w_last;

  // One restoring step: shift the next dividend bit into the partial remainder.
  // Since rem < B always holds, t - B fits in W bits whenever t >= B.
  assign w_t        = {r_rem, r_q[W-1]};
  assign w_ge       = (w_t >= {1'b0, r_b});
  assign w_rem_sub  = W'(w_t - {1'b0, r_b});
  assign w_rem_next = w_ge ? w_rem_sub : w_t[W-1:0];
  assign w_q_next   = {r_q[W-2:0], w_ge};
  assign w_last     = (r_count == CW'(W - 1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      A         <= '0;
      R         <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_b      <= B;
            r_rem    <= O[2*W-1:W];
            r_q      <= O[W-1:0];
            r_count  <= '0;
            in_ready <= 1'b0;
            if (B == '0) begin
              A         <= '1;
              R         <= '0;
              dz        <= 1'b1;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end else if (O[2*W-1:W] >= B) begin
              // Upper half already >= B: quotient cannot fit in W bits.
              A         <= '1;
              R         <= '0;
              dz        <= 1'b0;
              ovf       <= 1'b1;
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              dz      <= 1'b0;
              ovf     <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_rem   <= w_rem_next;
          r_q     <= w_q_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            A         <= w_q_next;
            R         <= w_rem_next;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          // Result held until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16u_seq.sv
// Testbench for div16u_seq: directed table, reset-mid-operation sequence and
// randomized operations checked against an arithmetic reference model.
module tb_div16u_seq;

  localparam int unsigned W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   O;
  logic [W-1:0]     B;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     A;
  logic [W-1:0]     R;
  logic             dz;
  logic             ovf;

  int n_vec;
  int n_err;

  div16u_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .O         (O),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .R         (R),
    .dz        (dz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic [7:0]  b;
    logic [7:0]  a;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the flag rules layered on top.
  task automatic model(input logic [15:0] o, input logic [7:0] b,
                       output logic [7:0] a, output logic [7:0] r,
                       output logic edz, output logic eovf);
    int unsigned q;
    edz = 1'b0; eovf = 1'b0; a = 8'hFF; r = 8'h00;
    if (b == 8'h00) begin
      edz = 1'b1;
    end else begin
      q = int'(o) / int'(b);
      if (q > 255) begin
        eovf = 1'b1;
      end else begin
        a = 8'(q);
        r = 8'(int'(o) % int'(b));
      end
    end
  endtask

  // Issue one operation, check latency, result, backpressure hold and release.
  // Called and returning at #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [15:0] o, input logic [7:0] b,
                        input logic [7:0] ea, input logic [7:0] er,
                        input logic edz, input logic eovf,
                        input int hold, input string tag);
    int n;
    int exp_lat;
    exp_lat = (edz || eovf) ? 0 : int'(W);
    in_valid = 1'b1;
    O = o;
    B = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the DUT must use its captured copy.
    O = 16'($urandom);
    B = 8'($urandom);
    in_valid = 1'($urandom);
    chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " A"}, 32'(A), 32'(ea));
    chk({tag, " R"}, 32'(R), 32'(er));
    chk({tag, " dz"}, 32'(dz), 32'(edz));
    chk({tag, " ovf"}, 32'(ovf), 32'(eovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " held result"}, {A, R, 6'd0, dz, ovf}, {ea, er, 6'd0, edz, eovf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    chk({tag, " result kept after handshake"}, {A, R, 6'd0, dz, ovf}, {ea, er, 6'd0, edz, eovf});
  endtask

  initial begin
    logic [15:0] ro;
    logic [7:0]  rb;
    logic [7:0]  ra;
    logic [7:0]  rr;
    logic        rdz;
    logic        rovf;
    int unsigned sel;
    int          n;

    n_vec = 0;
    n_err = 0;
    tbl[0] = '{o: 16'h1E61, b: 8'h58, a: 8'h58, r: 8'h21, dz: 1'b0, ovf: 1'b0, hold: 0};
    tbl[1] = '{o: 16'hFE01, b: 8'hFF, a: 8'hFF, r: 8'h00, dz: 1'b0, ovf: 1'b0, hold: 1};
    tbl[2] = '{o: 16'h1234, b: 8'h00, a: 8'hFF, r: 8'h00, dz: 1'b1, ovf: 1'b0, hold: 0};
    tbl[3] = '{o: 16'h0500, b: 8'h05, a: 8'hFF, r: 8'h00, dz: 1'b0, ovf: 1'b1, hold: 0};
    tbl[4] = '{o: 16'h04FF, b: 8'h05, a: 8'hFF, r: 8'h04, dz: 1'b0, ovf: 1'b0, hold: 0};
    tbl[5] = '{o: 16'h0D05, b: 8'h21, a: 8'h65, r: 8'h00, dz: 1'b0, ovf: 1'b0, hold: 5};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    O = '0;
    B = '0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset outputs", {A, R, 6'd0, dz, ovf}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].o, tbl[i].b, tbl[i].a, tbl[i].r, tbl[i].dz, tbl[i].ovf,
             tbl[i].hold, $sformatf("tbl%0d", i));

    // Reset while four iterations into a division.
    in_valid = 1'b1;
    O = 16'h1E61;
    B = 8'h58;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("midcalc busy", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midcalc reset out_valid", 32'(out_valid), 32'd0);
    chk("midcalc reset in_ready", 32'(in_ready), 32'd1);
    chk("midcalc reset outputs", {A, R, 6'd0, dz, ovf}, 32'd0);
    n = 0;
    while (n < 2) begin
      @(posedge clk); n++;
    end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post reset idle", 32'(in_ready), 32'd1);
    run_op(16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 0, "after_reset");

    // Randomized operations biased toward normal, boundary and flag cases.
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: begin
          ro = 16'($urandom);
          rb = 8'($urandom);
        end
        1: begin
          rb = 8'($urandom_range(1, 255));
          ra = 8'($urandom);
          rr = 8'($urandom_range(0, int'(rb) - 1));
          ro = 16'(int'(ra) * int'(rb) + int'(rr));
        end
        2: begin
          ro = 16'($urandom);
          rb = 8'h00;
        end
        3: begin
          rb = 8'($urandom_range(1, 255));
          ro = {rb, 8'($urandom)};
        end
        default: begin
          rb = 8'($urandom_range(1, 255));
          ro = 16'(int'(rb) * 256 - 1);
        end
      endcase
      model(ro, rb, ra, rr, rdz, rovf);
      run_op(ro, rb, ra, rr, rdz, rovf, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
